vector_lane_sequencer: RTL and testbench

Multi-cycle lane sequencer for the execute stage. Vector operations flagged as multi-cycle, such as vector multiply or divide-class ALU codes, do not use the wide combinational vector ALU. This block splits the 128-bit operands into 32-bit lanes and feeds them one per cycle through a single shared 32-bit scalar unit. While it runs, it holds the front of the pipeline with a stall, then returns the assembled 128-bit result to the EX/MEM register for one cycle.

---
 rtl/vector_lane_sequencer.sv | 82 ++++++++
 tb/tb_vector_lane_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: serialises multi-cycle vector ops lane by lane through one shared scalar unit
// Ports: clk/reset (async, active-high); ex_* = EX-stage instruction, operands and flush;
// lane_result = shared unit output; lane_* = shared unit operands; seq_stall holds the
// pipeline front; seq_done/seq_result return the assembled vector; seq_busy = not IDLE.
module vector_lane_sequencer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ex_valid,
    input  logic                    ex_multicycle,
    input  logic                    ex_flush,
    input  logic [3:0]              ex_alu_control,
    input  logic [LANES*LANE_W-1:0] ex_op1,
    input  logic [LANES*LANE_W-1:0] ex_op2,
    input  logic [LANE_W-1:0]       lane_result,
    output logic                    lane_valid,
    output logic [LANE_W-1:0]       lane_op1,
    output logic [LANE_W-1:0]       lane_op2,
    output logic [3:0]              lane_alu_control,
    output logic                    seq_stall,
    output logic                    seq_done,
    output logic [LANES*LANE_W-1:0] seq_result,
    output logic                    seq_busy
);
    localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state;
    logic [IW-1:0]           lane_idx;
    logic [LANES*LANE_W-1:0] op1_q, op2_q, result_q;
    logic [3:0]              ctl_q;
    logic                    start, run;

    assign start            = ex_valid & ex_multicycle & ~ex_flush;
    assign run              = state == RUN;
    assign lane_valid       = run;
    assign lane_op1         = run ? op1_q[lane_idx*LANE_W +: LANE_W] : '0;
    assign lane_op2         = run ? op2_q[lane_idx*LANE_W +: LANE_W] : '0;
    assign lane_alu_control = run ? ctl_q : '0;
    // gated by reset so every output reads 0 while reset is held, even with start pending
    assign seq_stall        = ~reset & ((state == IDLE & start) | run);
    assign seq_done         = state == DONE;
    assign seq_result       = seq_done ? result_q : '0;
    assign seq_busy         = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lane_idx <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            ctl_q    <= '0;
            result_q <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                op1_q    <= ex_op1;
                op2_q    <= ex_op2;
                ctl_q    <= ex_alu_control;
                lane_idx <= '0;
                result_q <= '0;
                state    <= RUN;
            end
        end else if (run) begin
            if (ex_flush) begin
                state <= IDLE;
            end else begin
                result_q[lane_idx*LANE_W +: LANE_W] <= lane_result;
                if (lane_idx == LAST)
                    state <= DONE;
                else
                    lane_idx <= lane_idx + 1'b1;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_vector_lane_sequencer.sv
// tb_vector_lane_sequencer: table-driven, hand-sequenced and random checks of vector_lane_sequencer
module tb_vector_lane_sequencer;
    localparam int LANES = 4;
    localparam int LW    = 32;
    localparam int VW    = LANES * LW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ex_valid = 1'b0, ex_multicycle = 1'b0, ex_flush = 1'b0;
    logic [3:0]    ex_alu_control = '0;
    logic [VW-1:0] ex_op1 = '0, ex_op2 = '0;
    logic [LW-1:0] lane_result;
    logic          lane_valid, seq_stall, seq_done, seq_busy;
    logic [LW-1:0] lane_op1, lane_op2;
    logic [3:0]    lane_alu_control;
    logic [VW-1:0] seq_result;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [VW-1:0] op1;
        logic [VW-1:0] op2;
        logic [3:0]    ctl;
        logic [VW-1:0] exp;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    vector_lane_sequencer #(.LANES(LANES), .LANE_W(LW)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_multicycle(ex_multicycle),
        .ex_flush(ex_flush), .ex_alu_control(ex_alu_control), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .lane_result(lane_result), .lane_valid(lane_valid), .lane_op1(lane_op1),
        .lane_op2(lane_op2), .lane_alu_control(lane_alu_control), .seq_stall(seq_stall),
        .seq_done(seq_done), .seq_result(seq_result), .seq_busy(seq_busy)
    );

    function automatic logic [LW-1:0] unit(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                            input logic [3:0] c);
        logic [LW-1:0] r;
        case (c)
            4'd0:    r = a * b;
            4'd1:    r = a + b;
            4'd2:    r = a - b;
            4'd3:    r = a ^ b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign lane_result = unit(lane_op1, lane_op2, lane_alu_control);

    function automatic logic [VW-1:0] model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                             input logic [3:0] c);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*LW +: LW] = unit(a[i*LW +: LW], b[i*LW +: LW], c);
        return r;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, " stall"}, VW'(seq_stall), '0);
        chk({name, " lane_valid"}, VW'(lane_valid), '0);
        chk({name, " busy"}, VW'(seq_busy), '0);
        chk({name, " done"}, VW'(seq_done), '0);
        chk({name, " lane_op1"}, VW'(lane_op1), '0);
        chk({name, " result"}, seq_result, '0);
    endtask

    task automatic drive_idle();
        @(negedge clk);
        ex_valid = 1'b0; ex_multicycle = 1'b0; ex_flush = 1'b0;
    endtask

    // issues one op at the next negedge (cycle T) and checks T..T+LANES+1; returns in DONE
    task automatic run_op(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [3:0] c,
                          input logic [VW-1:0] exp, input string name);
        @(negedge clk);
        ex_valid = 1'b1; ex_multicycle = 1'b1; ex_flush = 1'b0;
        ex_op1 = a; ex_op2 = b; ex_alu_control = c;
        #1;
        chk({name, " T stall"}, VW'(seq_stall), 1);
        chk({name, " T lane_valid"}, VW'(lane_valid), 0);
        for (int k = 0; k < LANES; k++) begin
            @(negedge clk);
            chk({name, " run stall"}, VW'(seq_stall), 1);
            chk({name, " run lane_valid"}, VW'(lane_valid), 1);
            chk({name, " run done"}, VW'(seq_done), 0);
            chk({name, " lane_op1"}, VW'(lane_op1), VW'(a[k*LW +: LW]));
            chk({name, " lane_op2"}, VW'(lane_op2), VW'(b[k*LW +: LW]));
            chk({name, " lane_ctl"}, VW'(lane_alu_control), VW'(c));
        end
        @(negedge clk);
        chk({name, " done"}, VW'(seq_done), 1);
        chk({name, " result"}, seq_result, exp);
        chk({name, " done stall"}, VW'(seq_stall), 0);
        chk({name, " done lane_valid"}, VW'(lane_valid), 0);
        chk({name, " done busy"}, VW'(seq_busy), 1);
    endtask

    initial begin
        vecs[0] = '{op1: {32'd4, 32'd3, 32'd2, 32'd1}, op2: {32'd8, 32'd7, 32'd6, 32'd5},
                    ctl: 4'd0, exp: {32'd32, 32'd21, 32'd12, 32'd5}};
        vecs[1] = '{op1: {32'd1, 32'h10000, 32'd3, 32'd2}, op2: {32'd5, 32'h10000, 32'd7, 32'd9},
                    ctl: 4'd0, exp: {32'd5, 32'd0, 32'd21, 32'd18}};
        vecs[2] = '{op1: {32'hFFFFFFFF, 32'd1, 32'd2, 32'd3}, op2: {32'd1, 32'd1, 32'd1, 32'd1},
                    ctl: 4'd1, exp: {32'd0, 32'd2, 32'd3, 32'd4}};
        vecs[3] = '{op1: {32'd0, 32'd5, 32'd10, 32'd0}, op2: {32'd1, 32'd1, 32'd1, 32'd0},
                    ctl: 4'd2, exp: {32'hFFFFFFFF, 32'd4, 32'd9, 32'd0}};

        // reset held with a start pending: everything must read 0
        ex_valid = 1'b1; ex_multicycle = 1'b1; ex_op1 = '1; ex_op2 = '1;
        #12;
        chk_quiet("reset");
        @(negedge clk);
        reset = 1'b0; ex_valid = 1'b0;

        // table vectors issued back-to-back; done pulses land 6 cycles apart by construction
        for (int i = 0; i < 4; i++) run_op(vecs[i].op1, vecs[i].op2, vecs[i].ctl, vecs[i].exp, $sformatf("vec%0d", i));
        drive_idle();
        #1 chk_quiet("after b2b");

        // non-multicycle traffic never engages the sequencer
        ex_valid = 1'b1; ex_multicycle = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("nonmc stall", VW'(seq_stall), 0);
            chk("nonmc lane_valid", VW'(lane_valid), 0);
            chk("nonmc busy", VW'(seq_busy), 0);
        end
        drive_idle();

        // flush at T+2 aborts with no done pulse
        @(negedge clk);
        ex_valid = 1'b1; ex_multicycle = 1'b1; ex_op1 = vecs[0].op1; ex_op2 = vecs[0].op2; ex_alu_control = 4'd0;
        @(negedge clk);
        @(negedge clk);
        ex_flush = 1'b1;
        #1 chk("flush T+2 stall", VW'(seq_stall), 1);
        @(negedge clk);
        ex_flush = 1'b0; ex_valid = 1'b0;
        #1 chk_quiet("flush T+3");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush no done", VW'(seq_done), 0);
            chk("flush no lane_valid", VW'(lane_valid), 0);
        end

        // async reset between edges mid-RUN, then a normal op
        @(negedge clk);
        ex_valid = 1'b1; ex_multicycle = 1'b1; ex_op1 = vecs[1].op1; ex_op2 = vecs[1].op2;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1; ex_valid = 1'b0;
        #1 chk_quiet("async reset");
        #1 reset = 1'b0;
        @(negedge clk);
        chk_quiet("post reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post reset no done", VW'(seq_done), 0);
        end
        run_op(vecs[0].op1, vecs[0].op2, vecs[0].ctl, vecs[0].exp, "after reset");
        drive_idle();

        // random ops against the lane-wise reference model, with random gaps
        for (int n = 0; n < 24; n++) begin
            logic [VW-1:0] a, b;
            logic [3:0]    c;
            for (int i = 0; i < LANES; i++) begin
                a[i*LW +: LW] = $urandom;
                b[i*LW +: LW] = $urandom;
            end
            c = 4'($urandom_range(0, 5));
            run_op(a, b, c, model(a, b, c), $sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                drive_idle();
                #1 chk_quiet("rand gap");
            end
        end
        drive_idle();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
